// File: rtl/tcbm_drive_responder.sv
// Drive-side TCBM responder: synchronises host DAV/data and runs the 4-phase DAV/ACK handshake per byte.
// Optional host-wait timeout abort is enabled by defining TCBM_TIMEOUT_EN.
module tcbm_drive_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       dav_in,
  output logic       ack_out,
  input  logic [7:0] host_data_in,
  output logic [7:0] host_data_out,
  output logic       host_data_oe,
  output logic [1:0] status_out,
  input  logic       tx_mode,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic [1:0] tx_status,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] rx_status,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE, RX_CAP, RX_HOLD, RX_ACK, TX_WAIT, TX_SETUP, TX_ACK, REL
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0]      dav_sync;
  logic [SYNC_STAGES-1:0][7:0] data_sync;
  logic                        dav_s;
  logic [7:0]                  data_s;

  logic       ack_n, oe_n, rx_valid_n, tx_ready_n;
  logic [7:0] hdo_n, rx_data_n;
  logic [1:0] status_n;
  // armed records that DAV was seen released, so a DAV left low never starts a second byte
  logic       armed, armed_n;

`ifdef TCBM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt, tmo_cnt_n;
  logic          timeout_n;
  logic          tmo_wait;
`endif

  always_ff @(posedge clock) begin
    if (!_reset) begin
      dav_sync  <= '1;
      data_sync <= '1;
    end else begin
      dav_sync  <= {dav_sync[SYNC_STAGES-2:0], dav_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], host_data_in};
    end
  end

  assign dav_s  = dav_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign busy   = (state != IDLE);

  always_comb begin
    state_n    = state;
    ack_n      = ack_out;
    oe_n       = host_data_oe;
    hdo_n      = host_data_out;
    status_n   = status_out;
    rx_data_n  = rx_data;
    rx_valid_n = rx_valid;
    tx_ready_n = 1'b0;
    armed_n    = armed;
    case (state)
      IDLE: begin
        if (!dav_s && armed) begin
          armed_n = 1'b0;
          state_n = tx_mode ? TX_WAIT : RX_CAP;
        end else if (dav_s) begin
          armed_n = 1'b1;
        end
      end
      RX_CAP: begin
        rx_data_n  = data_s;
        rx_valid_n = 1'b1;
        state_n    = RX_HOLD;
      end
      RX_HOLD: begin
        // a host abort takes priority over a same-cycle accept
        if (dav_s) begin
          rx_valid_n = 1'b0;
          state_n    = IDLE;
        end else if (rx_ready) begin
          rx_valid_n = 1'b0;
          status_n   = rx_status;
          ack_n      = 1'b0;
          state_n    = RX_ACK;
        end
      end
      RX_ACK: begin
        if (dav_s) state_n = REL;
      end
      TX_WAIT: begin
        if (dav_s) begin
          state_n = IDLE;
        end else if (tx_valid) begin
          hdo_n      = tx_data;
          status_n   = tx_status;
          oe_n       = 1'b1;
          tx_ready_n = 1'b1;
          state_n    = TX_SETUP;
        end
      end
      TX_SETUP: begin
        ack_n   = 1'b0;
        state_n = TX_ACK;
      end
      TX_ACK: begin
        if (dav_s) begin
          oe_n    = 1'b0;
          state_n = REL;
        end
      end
      REL: begin
        ack_n   = 1'b1;
        state_n = IDLE;
        if (dav_s) armed_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

`ifdef TCBM_TIMEOUT_EN
    // only a state still waiting on the host this cycle can time out
    timeout_n = 1'b0;
    tmo_wait  = (state == RX_ACK) || (state == TX_WAIT) || (state == TX_ACK);
    if (tmo_wait && (state_n == state) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1))) begin
      state_n    = IDLE;
      oe_n       = 1'b0;
      ack_n      = 1'b1;
      rx_valid_n = 1'b0;
      armed_n    = 1'b0;
      timeout_n  = 1'b1;
    end
    if (state_n != state || !tmo_wait) tmo_cnt_n = '0;
    else                               tmo_cnt_n = tmo_cnt + CW'(1);
`endif
  end

  always_ff @(posedge clock) begin
    if (!_reset) begin
      state         <= IDLE;
      ack_out       <= 1'b1;
      host_data_oe  <= 1'b0;
      host_data_out <= 8'h00;
      status_out    <= 2'b00;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      tx_ready      <= 1'b0;
      armed         <= 1'b0;
    end else begin
      state         <= state_n;
      ack_out       <= ack_n;
      host_data_oe  <= oe_n;
      host_data_out <= hdo_n;
      status_out    <= status_n;
      rx_data       <= rx_data_n;
      rx_valid      <= rx_valid_n;
      tx_ready      <= tx_ready_n;
      armed         <= armed_n;
    end
  end

`ifdef TCBM_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!_reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt     <= tmo_cnt_n;
      timeout_err <= timeout_n;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tcbm_drive_responder.sv
// Self-checking bench for tcbm_drive_responder: directed host transactions with exact-cycle
// expectations plus a per-cycle protocol/scoreboard check against the expected byte in flight.
module tb_tcbm_drive_responder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       dav_in;
  logic       ack_out;
  logic [7:0] host_data_in;
  logic [7:0] host_data_out;
  logic       host_data_oe;
  logic [1:0] status_out;
  logic       tx_mode;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic [1:0] tx_status;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] rx_status;
  logic       busy;
  logic       timeout_err;

  int compared   = 0;
  int mismatched = 0;

  // expected transaction in flight: what the cable/drive side must show for it
  logic       chk_en = 1'b0;
  logic       cur_tx = 1'b0;
  logic [7:0] exp_rx_byte = 8'h00;
  logic [1:0] exp_rx_stat = 2'b00;
  logic [7:0] exp_tx_byte = 8'h00;
  logic [1:0] exp_tx_stat = 2'b00;

  tcbm_drive_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), ._reset(reset_n), .dav_in(dav_in), .ack_out(ack_out),
    .host_data_in(host_data_in), .host_data_out(host_data_out), .host_data_oe(host_data_oe),
    .status_out(status_out), .tx_mode(tx_mode), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_status(tx_status), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_status(rx_status), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic dav, input logic [7:0] data, input logic rdy,
                               input logic [1:0] rstat);
    dav_in       = dav;
    host_data_in = data;
    rx_ready     = rdy;
    rx_status    = rstat;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // protocol rules that must hold on every cycle, independent of the test in progress
  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      if (!busy) begin
        checkOutput("idle_ack_released", ack_out, 1);
        checkOutput("idle_oe_released", host_data_oe, 0);
        checkOutput("idle_no_rx_valid", rx_valid, 0);
      end
      if (rx_valid) begin
        checkOutput("rx_ack_before_accept", ack_out, 1);
        checkOutput("rx_data_scoreboard", rx_data, exp_rx_byte);
      end
      if (host_data_oe) begin
        checkOutput("tx_data_scoreboard", host_data_out, exp_tx_byte);
        checkOutput("tx_status_scoreboard", status_out, exp_tx_stat);
      end
      if (!cur_tx && !ack_out) begin
        checkOutput("rx_status_scoreboard", status_out, exp_rx_stat);
        checkOutput("rx_no_drive", host_data_oe, 0);
      end
`ifndef TCBM_TIMEOUT_EN
      checkOutput("timeout_tied_low", timeout_err, 0);
`endif
    end
  end

  task automatic rxByte(input logic [7:0] d, input logic [1:0] st);
    cur_tx = 1'b0; exp_rx_byte = d; exp_rx_stat = st;
    applyStimulus(1'b0, d, 1'b1, st);
    tick(3);
    checkOutput("rx_valid_not_early", rx_valid, 0);
    checkOutput("rx_busy", busy, 1);
    tick(1);
    checkOutput("rx_valid_latency", rx_valid, 1);
    checkOutput("rx_data", rx_data, d);
    checkOutput("rx_ack_still_high", ack_out, 1);
    tick(1);
    checkOutput("rx_valid_one_pulse", rx_valid, 0);
    checkOutput("rx_ack_low", ack_out, 0);
    checkOutput("rx_status_out", status_out, {6'd0, st});
    applyStimulus(1'b1, d, 1'b0, st);
    tick(3);
    checkOutput("rx_ack_held_in_rel", ack_out, 0);
    tick(1);
    checkOutput("rx_ack_release", ack_out, 1);
    checkOutput("rx_done_idle", busy, 0);
  endtask

  task automatic txStart(input logic [7:0] d, input logic [1:0] st);
    cur_tx = 1'b1; exp_tx_byte = d; exp_tx_stat = st;
    tx_mode = 1'b1; tx_data = d; tx_status = st; tx_valid = 1'b1;
    dav_in = 1'b0;
    tick(3);
    checkOutput("tx_oe_not_early", host_data_oe, 0);
    checkOutput("tx_busy", busy, 1);
    tick(1);
    checkOutput("tx_oe", host_data_oe, 1);
    checkOutput("tx_data_out", host_data_out, d);
    checkOutput("tx_status_out", status_out, {6'd0, st});
    checkOutput("tx_ready_pulse", tx_ready, 1);
    checkOutput("tx_ack_setup_high", ack_out, 1);
    tx_valid = 1'b0; tx_mode = 1'b0;
    tick(1);
    checkOutput("tx_ready_one_pulse", tx_ready, 0);
    checkOutput("tx_ack_low", ack_out, 0);
    checkOutput("tx_oe_held", host_data_oe, 1);
  endtask

  task automatic txFinish();
    dav_in = 1'b1;
    tick(3);
    checkOutput("tx_oe_drop_first", host_data_oe, 0);
    checkOutput("tx_ack_still_low", ack_out, 0);
    tick(1);
    checkOutput("tx_ack_release", ack_out, 1);
    checkOutput("tx_done_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; tx_mode = 1'b0; tx_data = 8'h00; tx_status = 2'b00; tx_valid = 1'b0;
    applyStimulus(1'b1, 8'hFF, 1'b0, 2'b00);
    tick(3);
    checkOutput("reset_ack", ack_out, 1);
    checkOutput("reset_oe", host_data_oe, 0);
    checkOutput("reset_hdo", host_data_out, 8'h00);
    checkOutput("reset_status", status_out, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_tx_ready", tx_ready, 0);
    checkOutput("reset_timeout", timeout_err, 0);
    checkOutput("reset_busy", busy, 0);
    reset_n = 1'b1;
    tick(3);
    chk_en = 1'b1;

    rxByte(8'h81, 2'b00);
    tick(2);
    rxByte(8'hA5, 2'b10);
    tick(2);
    rxByte(8'h00, 2'b11);
    tick(2);

    txStart(8'h5A, 2'b01);
    txFinish();
    tick(2);

    // backpressure, with tx_mode toggled while the byte is held
    cur_tx = 1'b0; exp_rx_byte = 8'h42; exp_rx_stat = 2'b11;
    applyStimulus(1'b0, 8'h42, 1'b0, 2'b11);
    tick(4);
    checkOutput("bp_rx_valid", rx_valid, 1);
    tx_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("bp_ack_high", ack_out, 1);
      checkOutput("bp_rx_valid_held", rx_valid, 1);
    end
    checkOutput("bp_still_rx", host_data_oe, 0);
    rx_ready = 1'b1;
    tick(1);
    checkOutput("bp_ack_after_accept", ack_out, 0);
    checkOutput("bp_rx_valid_clear", rx_valid, 0);
    checkOutput("bp_status", status_out, 8'h03);
    rx_ready = 1'b0; tx_mode = 1'b0; dav_in = 1'b1;
    tick(4);
    checkOutput("bp_ack_release", ack_out, 1);
    checkOutput("bp_idle", busy, 0);
    tick(2);

    // host abort while waiting for tx data
    cur_tx = 1'b1; tx_mode = 1'b1; tx_valid = 1'b0; dav_in = 1'b0;
    tick(3);
    checkOutput("abort_tx_busy", busy, 1);
    dav_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("abort_tx_no_ready", tx_ready, 0);
      checkOutput("abort_tx_ack_high", ack_out, 1);
      checkOutput("abort_tx_no_oe", host_data_oe, 0);
    end
    checkOutput("abort_tx_idle", busy, 0);
    tx_mode = 1'b0;
    tick(2);

    // host abort in RX_HOLD arriving together with rx_ready
    cur_tx = 1'b0; exp_rx_byte = 8'h33; exp_rx_stat = 2'b01;
    applyStimulus(1'b0, 8'h33, 1'b0, 2'b01);
    tick(4);
    checkOutput("abort_rx_valid", rx_valid, 1);
    dav_in = 1'b1;
    tick(2);
    checkOutput("abort_rx_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    tick(1);
    checkOutput("abort_rx_dropped", rx_valid, 0);
    checkOutput("abort_rx_ack_high", ack_out, 1);
    checkOutput("abort_rx_idle", busy, 0);
    rx_ready = 1'b0;
    tick(2);

    // reset during TX_ACK releases the cable on the next edge
    txStart(8'hC3, 2'b10);
    reset_n = 1'b0;
    tick(1);
    checkOutput("rst_mid_oe", host_data_oe, 0);
    checkOutput("rst_mid_ack", ack_out, 1);
    checkOutput("rst_mid_idle", busy, 0);
    checkOutput("rst_mid_hdo", host_data_out, 8'h00);
    checkOutput("rst_mid_status", status_out, 8'h00);
    dav_in = 1'b1; reset_n = 1'b1;
    tick(4);
    rxByte(8'h7E, 2'b01);
    tick(2);

`ifdef TCBM_TIMEOUT_EN
    // host never releases DAV after the drive ACKs
    cur_tx = 1'b0; exp_rx_byte = 8'h11; exp_rx_stat = 2'b00;
    applyStimulus(1'b0, 8'h11, 1'b1, 2'b00);
    tick(5);
    checkOutput("tmo_ack_low", ack_out, 0);
    tick(15);
    checkOutput("tmo_not_early", timeout_err, 0);
    tick(1);
    checkOutput("tmo_pulse", timeout_err, 1);
    checkOutput("tmo_ack_release", ack_out, 1);
    checkOutput("tmo_idle", busy, 0);
    tick(1);
    checkOutput("tmo_pulse_one", timeout_err, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("tmo_no_retrigger", busy, 0);
    end
    dav_in = 1'b1;
    tick(3);
    rxByte(8'h11, 2'b00);
    tick(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
